bram_stream_reader: RTL and testbench

//  Sits directly downstream of the simple dual-port BRAM (1-cycle registered read, r_data updates only when r_valid).
//  On a command {base, len}, it issues len sequential BRAM reads and returns the words as a valid/ready stream.

---
 rtl/bram_stream_reader.sv | 176 +++++++++++++++++
 tb/tb_bram_stream_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : bram_stream_reader
//  Purpose  : Turns a {base, len} command into len sequential reads of a
//             simple dual-port BRAM (1-cycle registered read) and returns the
//             words as a valid/ready stream with an end-of-command marker.
//             Reads are only issued when the output FIFO is guaranteed to
//             have room for them, so back-pressure never drops or repeats a
//             word.
//  Ports    : clk, rst (async, active-low)
//             cmd_valid/cmd_ready/cmd_base/cmd_len  - command handshake
//             abort                                 - flush current command
//             mem_r_valid/mem_r_addr/mem_r_data     - BRAM read port
//             out_valid/out_ready/out_data/out_last - output stream
//             busy                                  - command in progress
//  Revision : 1.0 - initial release
// ============================================================================
module bram_stream_reader #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  abort,
    output logic                  mem_r_valid,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [WIDTH-1:0]      mem_r_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_CRD_W = c_PTR_W + 2;
    localparam int c_LEN_W = ADDR_WIDTH + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [c_LEN_W-1:0]    r_remaining;
    logic                  r_rd_valid;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_last;     // end-of-command tag riding with the read
    logic                  r_land;        // read data is on mem_r_data this cycle
    logic                  r_land_last;
    logic [WIDTH-1:0]      r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_last;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_nonempty;
    logic                  w_pop;
    logic                  w_head_last;
    logic                  w_abort;
    logic [c_CRD_W-1:0]    w_credit_used;
    logic                  w_issue;

    assign w_nonempty  = (r_count != '0);
    assign w_pop       = w_nonempty && out_ready;
    assign w_head_last = r_fifo_last[r_rd_ptr];
    assign w_abort     = abort && (r_state != c_IDLE);

    // Entries already held plus reads whose data has not yet been written.
    // A pop in the same cycle is deliberately not credited back.
    assign w_credit_used = c_CRD_W'(r_count) + c_CRD_W'(r_rd_valid) + c_CRD_W'(r_land);
    assign w_issue       = (r_state == c_FETCH) && (r_remaining != '0)
                           && (w_credit_used < c_CRD_W'(FIFO_DEPTH));

    assign cmd_ready   = (r_state == c_IDLE);
    assign busy        = (r_state != c_IDLE);
    assign mem_r_valid = r_rd_valid;
    assign mem_r_addr  = r_rd_addr;
    assign out_valid   = w_nonempty;
    assign out_data    = w_nonempty ? r_fifo_data[r_rd_ptr] : '0;
    assign out_last    = w_nonempty && w_head_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_remaining <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_last   <= 1'b0;
            r_land      <= 1'b0;
            r_land_last <= 1'b0;
            r_fifo_last <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
            end
        end else if (w_abort) begin
            // Clearing r_land discards the word of the last issued read,
            // which arrives on mem_r_data in the following cycle.
            r_state     <= c_IDLE;
            r_remaining <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_land      <= 1'b0;
            r_land_last <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_land      <= r_rd_valid;
            r_land_last <= r_rd_last;

            if (r_land) begin
                r_fifo_data[r_wr_ptr] <= mem_r_data;
                r_fifo_last[r_wr_ptr] <= r_land_last;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({r_land, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    // The first read goes out on the accepting edge so data
                    // reaches the stream three cycles after the handshake.
                    // The FIFO is empty and nothing is in flight here.
                    if (cmd_valid && (cmd_len != '0)) begin
                        r_rd_valid  <= 1'b1;
                        r_rd_addr   <= cmd_base;
                        r_rd_last   <= (cmd_len == c_LEN_W'(1));
                        r_remaining <= cmd_len - c_LEN_W'(1);
                        r_state     <= (cmd_len == c_LEN_W'(1)) ? c_DRAIN : c_FETCH;
                    end
                end
                c_FETCH: begin
                    if (w_issue) begin
                        r_rd_valid  <= 1'b1;
                        r_rd_addr   <= r_rd_addr + ADDR_WIDTH'(1);
                        r_rd_last   <= (r_remaining == c_LEN_W'(1));
                        r_remaining <= r_remaining - c_LEN_W'(1);
                        if (r_remaining == c_LEN_W'(1)) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    // The tagged word is the newest of the command, so when
                    // it leaves, nothing is left in the FIFO or in flight.
                    if (w_pop && w_head_last) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_stream_reader
//  Purpose  : Self-checking bench for bram_stream_reader. A BRAM model feeds
//             the reader; expected read addresses and stream words are built
//             per accepted command from base/len arithmetic and compared on
//             every cycle, with directed scenarios plus randomized commands.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

    localparam int AW    = 9;
    localparam int W     = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic          abort;
    logic          mem_r_valid;
    logic [AW-1:0] mem_r_addr;
    logic [W-1:0]  mem_r_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;

    logic [W-1:0]  mem [1 << AW];

    int errors = 0;
    int checks = 0;
    int n_pops = 0;

    logic [W:0]    exp_q [$];   // {last, data}
    logic [AW-1:0] addr_q [$];

    logic rand_ready = 1'b0;
    logic ready_force = 1'b1;

    bram_stream_reader #(
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_base    (cmd_base),
        .cmd_len     (cmd_len),
        .abort       (abort),
        .mem_r_valid (mem_r_valid),
        .mem_r_addr  (mem_r_addr),
        .mem_r_data  (mem_r_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // BRAM: registered read, output holds when not reading
    always @(posedge clk) begin
        if (mem_r_valid) mem_r_data <= mem[mem_r_addr];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Consumer ready: directed value or random, changed 2 units after the edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Reference model and per-cycle comparison
    initial begin : compare
        logic [W:0]    exp_w;
        logic [AW-1:0] a;
        logic          stall_hold;
        logic [W-1:0]  held_data;
        logic          held_last;
        stall_hold = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                addr_q.delete();
                stall_hold = 1'b0;
            end else begin
                if (mem_r_valid) begin
                    if (addr_q.size() == 0) check("extra_read", 1, 0);
                    else check("rd_addr", 64'(mem_r_addr), 64'(addr_q.pop_front()));
                end
                if (stall_hold) begin
                    check("stall_valid", 64'(out_valid), 1);
                    check("stall_data", out_data, held_data);
                    check("stall_last", 64'(out_last), 64'(held_last));
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word", 1, 0);
                    end else begin
                        exp_w = exp_q[0];
                        check("out_data", out_data, exp_w[W-1:0]);
                        check("out_last", 64'(out_last), 64'(exp_w[W]));
                    end
                end
                if (abort && busy) begin
                    exp_q.delete();
                    addr_q.delete();
                    stall_hold = 1'b0;
                end else begin
                    stall_hold = out_valid && !out_ready;
                    held_data  = out_data;
                    held_last  = out_last;
                    if (out_valid && out_ready && exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        n_pops++;
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        a = cmd_base + AW'(i);
                        addr_q.push_back(a);
                        exp_q.push_back({(i == int'(cmd_len) - 1), mem[a]});
                    end
                end
            end
        end
    end

    // Called at posedge+1 with the reader idle; returns at posedge+1 after accept
    task automatic send_cmd(input logic [AW-1:0] base, input logic [AW:0] len);
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_len   = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_idle"}, 64'(busy), 0);
        check({name, "_words_left"}, 64'(exp_q.size()), 0);
        check({name, "_reads_left"}, 64'(addr_q.size()), 0);
    endtask

    initial begin : stim
        int nr;
        int p0;
        int n;
        logic [AW-1:0] b;
        logic [AW:0]   l;

        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) mem[16 + i] = 64'h1111_2222_0000_0010 + 64'(i);

        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_base = '0;
        cmd_len = '0;
        abort = 1'b0;
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 1);
        check("rst_mem_r_valid", 64'(mem_r_valid), 0);
        check("rst_mem_r_addr", 64'(mem_r_addr), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_last", 64'(out_last), 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", 64'(busy), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: base 0x010, len 4, latency and back-to-back output
        ready_force = 1'b1;
        send_cmd(9'h010, 10'd4);
        @(negedge clk);   // T+1
        check("t1_first_read", 64'(mem_r_valid), 1);
        check("t1_first_addr", 64'(mem_r_addr), 64'h010);
        check("t1_early_out1", 64'(out_valid), 0);
        @(negedge clk);   // T+2
        check("t1_early_out2", 64'(out_valid), 0);
        @(negedge clk);   // T+3
        check("t1_first_valid", 64'(out_valid), 1);
        check("t1_first_data", out_data, 64'h1111_2222_0000_0010);
        check("t1_first_last", 64'(out_last), 0);
        @(negedge clk);
        check("t1_valid_w2", 64'(out_valid), 1);
        @(negedge clk);
        check("t1_valid_w3", 64'(out_valid), 1);
        @(negedge clk);   // T+6
        check("t1_valid_w4", 64'(out_valid), 1);
        check("t1_last_data", out_data, 64'h1111_2222_0000_0013);
        check("t1_last_flag", 64'(out_last), 1);
        @(negedge clk);   // T+7
        check("t1_busy_after", 64'(busy), 0);
        check("t1_valid_after", 64'(out_valid), 0);
        @(posedge clk);
        #1;
        wait_idle("t1", 50);

        // 2: address wrap
        send_cmd(9'h1FE, 10'd4);
        @(negedge clk);
        check("t2_addr0", 64'(mem_r_addr), 64'h1FE);
        @(negedge clk);
        check("t2_addr1", 64'(mem_r_addr), 64'h1FF);
        @(negedge clk);
        check("t2_addr2", 64'(mem_r_addr), 64'h000);
        @(negedge clk);
        check("t2_addr3", 64'(mem_r_addr), 64'h001);
        @(posedge clk);
        #1;
        wait_idle("t2", 50);

        // 3: stalled consumer, reads limited by FIFO room
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        send_cmd(9'h040, 10'd8);
        nr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_r_valid) nr++;
        end
        check("t3_stall_reads", 64'(nr), DEPTH);
        check("t3_stall_no_read", 64'(mem_r_valid), 0);
        check("t3_stall_valid", 64'(out_valid), 1);
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        wait_idle("t3", 100);

        // 4: zero length command
        send_cmd(9'h0AA, 10'd0);
        check("t4_ready", 64'(cmd_ready), 1);
        check("t4_busy", 64'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_no_read", 64'(mem_r_valid), 0);
            check("t4_no_out", 64'(out_valid), 0);
        end
        @(posedge clk);
        #1;

        // 5: abort after 5 pops, then a new command right away
        send_cmd(9'h100, 10'd16);
        p0 = n_pops;
        n = 0;
        while (n_pops - p0 < 5 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_five_pops", 64'(n_pops - p0), 5);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("t5_abort_valid", 64'(out_valid), 0);
        check("t5_abort_busy", 64'(busy), 0);
        check("t5_abort_ready", 64'(cmd_ready), 1);
        send_cmd(9'h0A0, 10'd2);
        wait_idle("t5", 50);

        // 6: asynchronous reset mid-command
        rand_ready = 1'b1;
        send_cmd(9'h155, 10'd12);
        repeat (4) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        check("t6_cmd_ready", 64'(cmd_ready), 1);
        check("t6_mem_r_valid", 64'(mem_r_valid), 0);
        check("t6_mem_r_addr", 64'(mem_r_addr), 0);
        check("t6_out_valid", 64'(out_valid), 0);
        check("t6_out_last", 64'(out_last), 0);
        check("t6_out_data", out_data, 0);
        check("t6_busy", 64'(busy), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        send_cmd(9'h033, 10'd6);
        wait_idle("t6", 100);

        // Randomized commands, random back-pressure and occasional abort
        for (int k = 0; k < 30; k++) begin
            b = AW'($urandom_range(0, (1 << AW) - 1));
            if (k == 10) l = 11'(1 << AW);
            else if ($urandom_range(0, 9) == 0) l = '0;
            else l = (AW + 1)'($urandom_range(1, 40));
            send_cmd(b, l);
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #1;
                if (busy) begin
                    abort = 1'b1;
                    @(posedge clk);
                    #1;
                    abort = 1'b0;
                end
            end
            wait_idle("rnd", 3000);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
